// File: rtl/sand_pkg.sv
// -----------------------------------------------------------------------------
// sand_pkg
// Shared definitions for the sand frame engine:
//   - cell codes stored in the frame-buffer RAM (EMPTY, SAND, WALL; any other
//     code behaves as WALL),
//   - the sweep FSM state type,
//   - small helpers for classifying a cell code.
// Cell-code helpers take a 32-bit code; callers zero-extend their cell data,
// so cell widths up to 32 bits are supported.
// -----------------------------------------------------------------------------
package sand_pkg;

    localparam int unsigned CELL_EMPTY = 0;
    localparam int unsigned CELL_SAND  = 1;
    localparam int unsigned CELL_WALL  = 2;

    // Explicit encodings keep the state values stable for existing
    // debug/trace tooling that decodes the raw state register.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_SRC    = 4'd2,
        ST_DOWN   = 4'd3,
        ST_DIAG_A = 4'd4,
        ST_DIAG_B = 4'd5,
        ST_MOVE   = 4'd6,
        ST_CLEAR  = 4'd7,
        ST_DONE   = 4'd8
    } state_e;

    function automatic logic is_empty(input logic [31:0] code);
        return code == 32'(CELL_EMPTY);
    endfunction

    function automatic logic is_sand(input logic [31:0] code);
        return code == 32'(CELL_SAND);
    endfunction

endpackage

// File: rtl/sand_scan_counter.sv
// -----------------------------------------------------------------------------
// sand_scan_counter
// Walks the source cells of one frame sweep: rows ACTIVE_ROWS-2 down to 0,
// columns left->right (dir_i=0) or right->left (dir_i=1). The linear address
// row*ACTIVE_COLUMNS+col is tracked incrementally alongside the row/col
// counters, so no multiplier is needed.
//
// Ports:
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   init_i       load the first source of a sweep (uses dir_i)
//   advance_i    step to the next source in scan order
//   dir_i        scan direction within a row (0: left->right, 1: right->left)
//   addr_o       address of the current source cell
//   next_addr_o  address of the source that follows the current one
//   first_col_o  current source is in column 0
//   last_col_o   current source is in column ACTIVE_COLUMNS-1
//   frame_end_o  current source is the last source of the sweep
// -----------------------------------------------------------------------------
module sand_scan_counter #(
    parameter int unsigned ACTIVE_COLUMNS = 640,
    parameter int unsigned ACTIVE_ROWS    = 480,
    parameter int unsigned ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  init_i,
    input  logic                  advance_i,
    input  logic                  dir_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  first_col_o,
    output logic                  last_col_o,
    output logic                  frame_end_o
);

    localparam int unsigned COL_W = $clog2(ACTIVE_COLUMNS);
    localparam int unsigned ROW_W = $clog2(ACTIVE_ROWS);

    localparam logic [COL_W-1:0]      COL_LAST     = COL_W'(ACTIVE_COLUMNS - 1);
    localparam logic [ROW_W-1:0]      ROW_START    = ROW_W'(ACTIVE_ROWS - 2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_START_L = ADDR_WIDTH'((ACTIVE_ROWS - 2) * ACTIVE_COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_START_R = ADDR_WIDTH'((ACTIVE_ROWS - 1) * ACTIVE_COLUMNS - 1);
    // Going from the right end of row r to the left end of row r-1.
    localparam logic [ADDR_WIDTH-1:0] ROW_BACK     = ADDR_WIDTH'(2 * ACTIVE_COLUMNS - 1);

    logic [COL_W-1:0]      col_q,  col_d;
    logic [ROW_W-1:0]      row_q,  row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  row_end;

    assign row_end = dir_i ? (col_q == '0) : (col_q == COL_LAST);

    always_comb begin
        if (row_end) begin
            row_d = row_q - 1'b1;
            col_d = dir_i ? COL_LAST : '0;
            // Right->left: the left end of row r is followed by the right end
            // of row r-1, which is simply the previous address.
            addr_d = dir_i ? (addr_q - 1'b1) : (addr_q - ROW_BACK);
        end else begin
            row_d  = row_q;
            col_d  = dir_i ? (col_q - 1'b1) : (col_q + 1'b1);
            addr_d = dir_i ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (init_i) begin
            row_q  <= ROW_START;
            col_q  <= dir_i ? COL_LAST : '0;
            addr_q <= dir_i ? ADDR_START_R : ADDR_START_L;
        end else if (advance_i) begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o      = addr_q;
    assign next_addr_o = addr_d;
    assign first_col_o = (col_q == '0);
    assign last_col_o  = (col_q == COL_LAST);
    assign frame_end_o = row_end && (row_q == '0);

endmodule

// File: rtl/sand_frame_engine.sv
// -----------------------------------------------------------------------------
// sand_frame_engine
// Sweeps the cell frame buffer once per start_i, moving every SAND cell down,
// then along the preferred diagonal, then the other diagonal, into EMPTY
// space. The preferred diagonal alternates each frame (parity) so piles spread
// symmetrically. Talks to a RAM with one synchronous read port (data one cycle
// after the address) and one write port.
//
// Ports:
//   clk_i            clock
//   reset_ni         asynchronous active-low reset
//   start_i          begin one frame sweep (sampled only when idle)
//   pixel_state_i    RAM read data for the address driven the previous cycle
//   read_address_o   RAM read address
//   write_address_o  RAM write address (0 when not writing)
//   write_data_o     RAM write data (0 when not writing)
//   wr_ena_o         RAM write enable
//   busy_o           sweep in progress
//   done_o           one-cycle end-of-sweep pulse
//   moves_o          grains moved in the last completed sweep
// -----------------------------------------------------------------------------
module sand_frame_engine #(
    parameter int unsigned ACTIVE_COLUMNS = 640,
    parameter int unsigned ACTIVE_ROWS    = 480,
    parameter int unsigned ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int unsigned DATA_WIDTH     = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] pixel_state_i,
    output logic [ADDR_WIDTH-1:0] read_address_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  wr_ena_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] moves_o
);

    import sand_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] OFS_DOWN  = ADDR_WIDTH'(ACTIVE_COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] OFS_LEFT  = ADDR_WIDTH'(ACTIVE_COLUMNS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFS_RIGHT = ADDR_WIDTH'(ACTIVE_COLUMNS + 1);

    state_e                state_q, state_d;
    logic                  parity_q, parity_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] moves_q, moves_d;
    logic [ADDR_WIDTH-1:0] probe_q, probe_d;

    logic                  scan_init, scan_advance;
    logic [ADDR_WIDTH-1:0] src_addr, next_src_addr;
    logic                  first_col, last_col, frame_end;

    logic [ADDR_WIDTH-1:0] addr_down, addr_left, addr_right;
    logic [ADDR_WIDTH-1:0] pref_addr, other_addr;
    logic                  pref_ok, other_ok;
    logic                  cell_empty, cell_sand;
    logic                  leave_source;

    sand_scan_counter #(
        .ACTIVE_COLUMNS (ACTIVE_COLUMNS),
        .ACTIVE_ROWS    (ACTIVE_ROWS),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_scan (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .init_i      (scan_init),
        .advance_i   (scan_advance),
        .dir_i       (parity_q),
        .addr_o      (src_addr),
        .next_addr_o (next_src_addr),
        .first_col_o (first_col),
        .last_col_o  (last_col),
        .frame_end_o (frame_end)
    );

    assign addr_down  = src_addr + OFS_DOWN;
    assign addr_left  = src_addr + OFS_LEFT;
    assign addr_right = src_addr + OFS_RIGHT;

    // parity 0 prefers down-left, parity 1 prefers down-right.
    assign pref_addr  = parity_q ? addr_right : addr_left;
    assign other_addr = parity_q ? addr_left  : addr_right;
    assign pref_ok    = parity_q ? !last_col  : !first_col;
    assign other_ok   = parity_q ? !first_col : !last_col;

    assign cell_empty = is_empty(32'(pixel_state_i));
    assign cell_sand  = is_sand(32'(pixel_state_i));

    always_comb begin
        state_d         = state_q;
        parity_d        = parity_q;
        cnt_d           = cnt_q;
        moves_d         = moves_q;
        probe_d         = probe_q;
        scan_init       = 1'b0;
        scan_advance    = 1'b0;
        leave_source    = 1'b0;
        read_address_o  = '0;
        write_address_o = '0;
        write_data_o    = '0;
        wr_ena_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    scan_init = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                read_address_o = src_addr;
                state_d        = ST_SRC;
            end
            ST_SRC: begin
                if (cell_sand) begin
                    read_address_o = addr_down;
                    probe_d        = addr_down;
                    state_d        = ST_DOWN;
                end else begin
                    leave_source = 1'b1;
                end
            end
            ST_DOWN: begin
                if (cell_empty) begin
                    state_d = ST_MOVE;
                end else if (pref_ok) begin
                    read_address_o = pref_addr;
                    probe_d        = pref_addr;
                    state_d        = ST_DIAG_A;
                end else begin
                    // With at least two columns, a missing preferred
                    // diagonal means the other one exists.
                    read_address_o = other_addr;
                    probe_d        = other_addr;
                    state_d        = ST_DIAG_B;
                end
            end
            ST_DIAG_A: begin
                if (cell_empty) begin
                    state_d = ST_MOVE;
                end else if (other_ok) begin
                    read_address_o = other_addr;
                    probe_d        = other_addr;
                    state_d        = ST_DIAG_B;
                end else begin
                    leave_source = 1'b1;
                end
            end
            ST_DIAG_B: begin
                if (cell_empty) begin
                    state_d = ST_MOVE;
                end else begin
                    leave_source = 1'b1;
                end
            end
            ST_MOVE: begin
                wr_ena_o        = 1'b1;
                write_address_o = probe_q;
                write_data_o    = DATA_WIDTH'(CELL_SAND);
                cnt_d           = cnt_q + 1'b1;
                state_d         = ST_CLEAR;
            end
            ST_CLEAR: begin
                wr_ena_o        = 1'b1;
                write_address_o = src_addr;
                write_data_o    = DATA_WIDTH'(CELL_EMPTY);
                leave_source    = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Finishing a source either ends the sweep or steps the scan and
        // issues the next source read in the same cycle. The move count and
        // parity are committed on entry to DONE so that moves_o changes in
        // the same cycle done_o pulses.
        if (leave_source) begin
            if (frame_end) begin
                state_d  = ST_DONE;
                moves_d  = cnt_q;
                cnt_d    = '0;
                parity_d = ~parity_q;
            end else begin
                scan_advance   = 1'b1;
                read_address_o = next_src_addr;
                state_d        = ST_SRC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            cnt_q    <= '0;
            moves_q  <= '0;
            probe_q  <= '0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            moves_q  <= moves_d;
            probe_q  <= probe_d;
        end
    end

    assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o  = (state_q == ST_DONE);
    assign moves_o = moves_q;

endmodule

// File: tb/tb_sand_frame_engine.sv
// -----------------------------------------------------------------------------
// tb_sand_frame_engine
// Bench for sand_frame_engine on a 4x4 grid with a behavioural frame-buffer
// RAM and a grid-level reference model of one sweep.
// -----------------------------------------------------------------------------
module tb_sand_frame_engine;

    localparam int C  = 4;
    localparam int R  = 4;
    localparam int N  = C * R;
    localparam int AW = 4;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          start_i;
    logic [DW-1:0] pixel_state_i;
    logic [AW-1:0] read_address_o;
    logic [AW-1:0] write_address_o;
    logic [DW-1:0] write_data_o;
    logic          wr_ena_o;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] moves_o;

    always #5 clk = ~clk;

    sand_frame_engine #(
        .ACTIVE_COLUMNS (C),
        .ACTIVE_ROWS    (R),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .start_i         (start_i),
        .pixel_state_i   (pixel_state_i),
        .read_address_o  (read_address_o),
        .write_address_o (write_address_o),
        .write_data_o    (write_data_o),
        .wr_ena_o        (wr_ena_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .moves_o         (moves_o)
    );

    // Frame-buffer RAM: read-first, data one cycle after the address.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] img [N];
    logic          load_req;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (wr_ena_o) begin
            mem[write_address_o] <= write_data_o;
        end
        pixel_state_i <= mem[read_address_o];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference state
    int gold [N];
    int start_grid [N];
    int exp_wr [$];
    int exp_all [$];
    int exp_cycles;
    int exp_moves;
    int par_m;
    int wr_in_frame;
    bit mon_en;
    int mon_e;

    // Grid-level model of one sweep: updates gold in place, records the
    // expected write stream, move count and cycle count.
    task automatic model_frame(input int par);
        int c, src, dst;
        int cand [3];
        exp_wr.delete();
        exp_cycles = 2;
        exp_moves  = 0;
        for (int r = R - 2; r >= 0; r--) begin
            for (int k = 0; k < C; k++) begin
                c   = (par != 0) ? (C - 1 - k) : k;
                src = r * C + c;
                exp_cycles++;
                if (gold[src] == 1) begin
                    cand[0] = c;
                    cand[1] = (par != 0) ? c + 1 : c - 1;
                    cand[2] = (par != 0) ? c - 1 : c + 1;
                    for (int j = 0; j < 3; j++) begin
                        if (cand[j] >= 0 && cand[j] < C) begin
                            dst = (r + 1) * C + cand[j];
                            exp_cycles++;
                            if (gold[dst] == 0) begin
                                gold[dst] = 1;
                                gold[src] = 0;
                                exp_wr.push_back(dst * 256 + 1);
                                exp_wr.push_back(src * 256 + 0);
                                exp_cycles += 2;
                                exp_moves++;
                                break;
                            end
                        end
                    end
                end
            end
        end
        exp_all = exp_wr;
    endtask

    // Per-cycle write-port checker against the expected write stream.
    always @(negedge clk) begin
        if (reset_ni && mon_en) begin
            if (wr_ena_o) begin
                wr_in_frame++;
                if (exp_wr.size() == 0) begin
                    chk("write_unexpected", int'(write_address_o) * 256 + int'(write_data_o), -1);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("write", int'(write_address_o) * 256 + int'(write_data_o), mon_e);
                end
            end else begin
                chk("idle_write_bus", int'(write_address_o) * 256 + int'(write_data_o), 0);
            end
            if (done_o) chk("done_busy_overlap", int'(busy_o), 0);
        end
    end

    function automatic int all_outs();
        return int'({read_address_o, write_address_o, write_data_o, wr_ena_o,
                     busy_o, done_o, moves_o});
    endfunction

    function automatic int sand_count();
        int n = 0;
        for (int i = 0; i < N; i++) if (mem[i] == 2'd1) n++;
        return n;
    endfunction

    task automatic clear_gold();
        for (int i = 0; i < N; i++) gold[i] = 0;
    endtask

    task automatic load_grid();
        for (int i = 0; i < N; i++) img[i] = 2'(gold[i]);
        load_req = 1'b1;
        @(posedge clk); #2;
        load_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        @(posedge clk); #2;
        reset_ni = 1'b1;
        par_m = 0;
        exp_wr.delete();
    endtask

    task automatic grid_check(input string nm);
        int diff = 0;
        for (int i = 0; i < N; i++) if (int'(mem[i]) != gold[i]) diff++;
        chk(nm, diff, 0);
    endtask

    task automatic start_frame();
        start_grid  = gold;
        model_frame(par_m);
        wr_in_frame = 0;
        start_i     = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
    endtask

    task automatic finish_frame(output int lat, output int mv);
        lat = 1;
        mv  = -1;
        while (!done_o && lat < 400) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("done_seen", int'(done_o), 1);
        if (done_o) begin
            chk("frame_cycles", lat, exp_cycles);
            chk("moves", int'(moves_o), exp_moves);
            mv    = int'(moves_o);
            par_m ^= 1;
        end
        @(posedge clk); #2;
        chk("done_pulse", int'({done_o, busy_o}), 0);
        chk("pending_writes", exp_wr.size(), 0);
        grid_check("grid");
    endtask

    task automatic run_frame(output int lat, output int mv);
        start_frame();
        finish_frame(lat, mv);
    endtask

    int lat, mv, k, nmove;
    int exp_mv [4] = '{1, 1, 1, 0};

    initial begin
        reset_ni = 1'b0;
        start_i  = 1'b0;
        load_req = 1'b0;
        mon_en   = 1'b0;
        par_m    = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", all_outs(), 0);
        reset_ni = 1'b1;
        mon_en   = 1'b1;

        // Single grain falls one row per frame.
        clear_gold();
        gold[1] = 1;
        load_grid();
        for (int f = 0; f < 4; f++) begin
            run_frame(lat, mv);
            chk("t1_moves_literal", mv, exp_mv[f]);
        end
        chk("t1_final_pos", int'(mem[13]), 1);
        chk("t1_sand_count", sand_count(), 1);

        // Blocked grain takes the preferred diagonal (parity 0: left).
        do_reset();
        clear_gold();
        gold[9] = 1; gold[13] = 2;
        load_grid();
        run_frame(lat, mv);
        chk("t2_left_dest", int'(mem[12]), 1);
        chk("t2_src_cleared", int'(mem[9]), 0);

        // Empty frame, then the same blocked grain with parity 1: right.
        do_reset();
        clear_gold();
        load_grid();
        run_frame(lat, mv);
        chk("t3_empty_latency", lat, 14);
        chk("t3_empty_writes", wr_in_frame, 0);
        chk("t3_empty_moves", mv, 0);
        clear_gold();
        gold[9] = 1; gold[13] = 2;
        load_grid();
        run_frame(lat, mv);
        chk("t3_right_dest", int'(mem[14]), 1);

        // Column 0 grain: left probe skipped, 5-cycle source.
        do_reset();
        clear_gold();
        gold[8] = 1; gold[12] = 2;
        load_grid();
        run_frame(lat, mv);
        chk("t4_latency", lat, 18);
        chk("t4_dest", int'(mem[13]), 1);

        // Sand column over a wall floor.
        do_reset();
        clear_gold();
        gold[2] = 1; gold[6] = 1; gold[10] = 1;
        for (int i = 12; i < 16; i++) gold[i] = 2;
        load_grid();
        run_frame(lat, mv);
        chk("t5_moves", mv, 2);
        chk("t5_sand_count", sand_count(), 3);
        chk("t5_cells", int'({mem[6], mem[9], mem[10]}), 21);

        // Reset during the second MOVE, then rerun the frame.
        do_reset();
        clear_gold();
        for (int i = 0; i < 4; i++) gold[i] = 1;
        load_grid();
        start_frame();
        nmove = 0;
        for (int t = 0; t < 200 && nmove < 2; t++) begin
            if (wr_ena_o && write_data_o == 2'd1) nmove++;
            if (nmove < 2) begin
                @(posedge clk); #2;
            end
        end
        chk("t6_second_move_seen", nmove, 2);
        k = exp_all.size() - exp_wr.size();
        reset_ni = 1'b0;
        #1;
        chk("t6_reset_outputs", all_outs(), 0);
        chk("t6_committed_writes", k, 2);
        gold = start_grid;
        for (int i = 0; i < k; i++) gold[exp_all[i] / 256] = exp_all[i] % 256;
        exp_wr.delete();
        @(posedge clk); #2;
        reset_ni = 1'b1;
        par_m = 0;
        @(posedge clk); #2;
        grid_check("t6_grid_after_reset");
        chk("t6_idle_after_reset", int'(busy_o), 0);
        run_frame(lat, mv);
        chk("t6_sand_count", sand_count(), 4);

        // Randomised grids, several frames each.
        for (int t = 0; t < 8; t++) begin
            if (t == 4) do_reset();
            for (int i = 0; i < N; i++) begin
                int v = $urandom_range(0, 9);
                gold[i] = (v < 4) ? 0 : (v < 7) ? 1 : (v < 9) ? 2 : 3;
            end
            load_grid();
            for (int f = 0; f < 3; f++) run_frame(lat, mv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
